squid_stream_encoder: RTL and testbench
=======================================

Name: squid_stream_encoder

Overview:
- Parametrised, streaming successor to the fixed 8x6-bit SQUID block encoder.
- Accepts one block of N_WEIGHTS two's-complement weights per input handshake. Each weight is quantised to a C_BITS code; codes are saturated for outliers.
- Emits one header beat holding all codes and an outlier bitmap, then one escape beat per outlier carrying its index and full-precision value.
- Sits between the weight loader and the compressed-weight writer; valid/ready on both sides.

Parameters:
- N_WEIGHTS, 8, weights per block (>=2).
- W_BITS, 6, input weight width, signed.
- C_BITS, 4, compressed code width, signed (2 <= C_BITS < W_BITS).
- IDX_W, $clog2(N_WEIGHTS), derived; escape index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  block present on in_weights.
- in_ready  out  1  encoder can accept a block.
- in_weights  in  N_WEIGHTS*W_BITS  weight i at bits [i*W_BITS +: W_BITS].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_is_esc  out  1  0 = header beat, 1 = escape beat.
- out_codes  out  N_WEIGHTS*C_BITS  code i at [i*C_BITS +: C_BITS]; valid on header beat.
- out_bitmap  out  N_WEIGHTS  bit i set = weight i is an outlier; valid on header beat.
- out_idx  out  IDX_W  outlier index; valid on escape beat.
- out_value  out  W_BITS  full outlier value; valid on escape beat.
- out_last  out  1  final beat of the block.

Behaviour:
- Single clock; reset is asynchronous and active-low (rst_n); all state clears immediately on assertion.
- Reset values: state=IDLE, out_valid=0, out_is_esc=0, out_last=0, out_codes=0, out_bitmap=0, out_idx=0, out_value=0, pending mask=0. in_ready is 1 once in IDLE.
- Classification: let LO=-2^(C_BITS-1) and HI=2^(C_BITS-1)-1. A weight w is an inlier iff LO <= w <= HI; its code is w[C_BITS-1:0]. Otherwise it is an outlier; its code is HI if w>0, else LO.
- Input handshake: a block is accepted on a clk edge with in_valid && in_ready. The block, the codes and the bitmap are registered at that edge. The pending mask is loaded with the bitmap.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept -> HDR.
  - HDR: out_valid=1, out_is_esc=0, out_last=(bitmap==0). On handshake: if bitmap==0, go to IDLE (or reload, see back-to-back); else go to ESC.
  - ESC: out_valid=1, out_is_esc=1, out_idx=lowest set index in the pending mask, out_value=weight[out_idx], out_last=(popcount(pending)==1). On handshake, clear that bit. If it was the last bit, go to IDLE (or reload); otherwise stay in ESC.
- Ordering: escape beats are emitted in strictly ascending index order.
- Back-to-back: in_ready=1 also in HDR/ESC during the cycle where out_valid && out_ready && out_last. A block accepted in that cycle goes directly to HDR, with no idle bubble. in_ready is 0 otherwise.
- Latency: header is valid the cycle after acceptance. A block with k outliers occupies k+1 output beats. Sustained throughput is 1 block per k+1 cycles.
- Backpressure: while out_valid && !out_ready, all out_* signals hold stable and the pending mask does not change.
- in_valid is ignored when in_ready=0. in_weights is sampled only on the accepting edge.
- All-outlier block: N_WEIGHTS escape beats; only the last carries out_last.
- Reset mid-block: the partially emitted block is discarded and no further beats are produced. After reset, the first beat is the header of the next accepted block.

Test Plan:
- Defaults; weights (idx0..7) = [3,-8,7,20,-9,0,0,-32], out_ready=1 -> header next cycle: codes = [0x3,0x8,0x7,0x7,0x8,0x0,0x0,0x8], bitmap=0x98, last=0. Escapes follow: (idx3, 0x14), (idx4, 0x37), (idx7, 0x20). out_last is set on the third escape. Total 4 beats.
- All inliers [0,1,-1,7,-8,2,-2,5] -> single header beat with bitmap=0x00 and last=1. A second block presented on the same cycle is accepted with no bubble; its header appears the next cycle.
- All-outlier block, all weights = 31 -> codes all 0x7, bitmap=0xFF. Eight escapes idx0..7, each with value 0x1F; last only on idx7.
- Example 1 with out_ready toggling 1,0,0,1 on each beat -> outputs are held bit-stable across stall cycles. Beat sequence is identical to the unstalled run. in_ready stays 0 until the final handshake.
- rst_n asserted asynchronously mid-escape (after idx3 is sent) -> out_valid drops immediately and in_ready=1 after release. The next block's header is produced with no leftover idx4/idx7 beats.
- Parameter sweep N_WEIGHTS=16, W_BITS=8, C_BITS=3 with weight 4 at idx 9, others 0 -> code9=0x3 and bitmap=0x0200. One escape beat (idx 9, value 0x04, last=1).

Source files
------------

// File: rtl/squid_stream_encoder_if.sv
// Stream bundle for the SQUID encoder: weight-block input channel and
// compressed-beat output channel, both valid/ready.
interface squid_stream_encoder_if #(
   parameter int unsigned N_WEIGHTS = 8,
   parameter int unsigned W_BITS    = 6,
   parameter int unsigned C_BITS    = 4
) ();
   localparam int unsigned IDX_W = $clog2(N_WEIGHTS);

   logic                          in_valid;
   logic                          in_ready;
   logic [N_WEIGHTS*W_BITS-1:0]   in_weights;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_is_esc;
   logic [N_WEIGHTS*C_BITS-1:0]   out_codes;
   logic [N_WEIGHTS-1:0]          out_bitmap;
   logic [IDX_W-1:0]              out_idx;
   logic [W_BITS-1:0]             out_value;
   logic                          out_last;

   modport master (
      output in_valid, in_weights, out_ready,
      input  in_ready, out_valid, out_is_esc, out_codes, out_bitmap, out_idx, out_value,
             out_last
   );

   modport slave (
      input  in_valid, in_weights, out_ready,
      output in_ready, out_valid, out_is_esc, out_codes, out_bitmap, out_idx, out_value,
             out_last
   );
endinterface

// File: rtl/squid_stream_encoder.sv
// Streaming SQUID encoder: quantises a block of weights to saturated codes, emits a header
// beat (codes + outlier bitmap) followed by one escape beat per outlier in ascending order.
module squid_stream_encoder #(
   parameter int unsigned N_WEIGHTS = 8,
   parameter int unsigned W_BITS    = 6,
   parameter int unsigned C_BITS    = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   squid_stream_encoder_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(N_WEIGHTS);
   localparam int HiVal = (1 << (C_BITS - 1)) - 1;
   localparam int LoVal = -(1 << (C_BITS - 1));
   localparam logic [C_BITS-1:0] CodeHi = {1'b0, {(C_BITS-1){1'b1}}};
   localparam logic [C_BITS-1:0] CodeLo = {1'b1, {(C_BITS-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StHdr, StEsc} state_e;

   state_e                      state_q, state_d;
   logic [N_WEIGHTS*W_BITS-1:0] weights_q;
   logic [N_WEIGHTS*C_BITS-1:0] codes_q, codes_in;
   logic [N_WEIGHTS-1:0]        bitmap_q, bitmap_in;
   logic [N_WEIGHTS-1:0]        pending_q, pending_d;

   logic signed [W_BITS-1:0]    w;
   logic [IDX_W-1:0]            esc_idx;
   logic [N_WEIGHTS-1:0]        esc_hot;
   logic                        esc_last;
   logic                        valid, last, done, ready, accept;

   always_comb begin
      codes_in  = '0;
      bitmap_in = '0;
      w         = '0;
      for (int i = 0; i < int'(N_WEIGHTS); i++) begin
         w = bus.in_weights[i*W_BITS +: W_BITS];
         if (int'(w) > HiVal) begin
            bitmap_in[i]                   = 1'b1;
            codes_in[i*C_BITS +: C_BITS]   = CodeHi;
         end else if (int'(w) < LoVal) begin
            bitmap_in[i]                   = 1'b1;
            codes_in[i*C_BITS +: C_BITS]   = CodeLo;
         end else begin
            codes_in[i*C_BITS +: C_BITS]   = w[C_BITS-1:0];
         end
      end
   end

   // Scan downwards so the lowest pending index wins.
   always_comb begin
      esc_idx = '0;
      esc_hot = '0;
      for (int i = int'(N_WEIGHTS) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            esc_idx    = IDX_W'(i);
            esc_hot    = '0;
            esc_hot[i] = 1'b1;
         end
      end
      esc_last = (pending_q & (pending_q - N_WEIGHTS'(1))) == '0;
   end

   always_comb begin
      valid = state_q != StIdle;
      last  = 1'b0;
      if (state_q == StHdr) last = bitmap_q == '0;
      if (state_q == StEsc) last = esc_last;
      done   = valid && bus.out_ready && last;
      ready  = (state_q == StIdle) || done;
      accept = bus.in_valid && ready;

      bus.in_ready   = ready;
      bus.out_valid  = valid;
      bus.out_is_esc = state_q == StEsc;
      bus.out_last   = last;
      bus.out_codes  = codes_q;
      bus.out_bitmap = bitmap_q;
      bus.out_idx    = esc_idx;
      bus.out_value  = weights_q[esc_idx*W_BITS +: W_BITS];
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StHdr;
         StHdr: begin
            if (bus.out_ready) state_d = (bitmap_q == '0) ? StIdle : StEsc;
         end
         StEsc: begin
            if (bus.out_ready) begin
               pending_d = pending_q & ~esc_hot;
               if (esc_last) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A block accepted on the final handshake chains straight into its header.
      if (accept) begin
         state_d   = StHdr;
         pending_d = bitmap_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pending_q <= '0;
         weights_q <= '0;
         codes_q   <= '0;
         bitmap_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (accept) begin
            weights_q <= bus.in_weights;
            codes_q   <= codes_in;
            bitmap_q  <= bitmap_in;
         end
      end
   end
endmodule

// File: tb/tb_squid_stream_encoder.sv
// Directed bench for squid_stream_encoder: table of hand-computed blocks plus
// back-to-back, stall, mid-block reset and a wider parameter set.
module tb_squid_stream_encoder;
   typedef struct {
      logic [7:0][5:0] w;
      logic [31:0]     codes;
      logic [7:0]      bitmap;
      int              n_esc;
      logic [7:0][2:0] idx;
      logic [7:0][5:0] val;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vecs[4];

   always #5 clk = ~clk;

   squid_stream_encoder_if #(.N_WEIGHTS(8), .W_BITS(6), .C_BITS(4)) bus ();
   squid_stream_encoder_if #(.N_WEIGHTS(16), .W_BITS(8), .C_BITS(3)) bus16 ();

   squid_stream_encoder #(.N_WEIGHTS(8), .W_BITS(6), .C_BITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   squid_stream_encoder #(.N_WEIGHTS(16), .W_BITS(8), .C_BITS(3)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] snap();
      return {12'h0, bus.out_valid, bus.out_is_esc, bus.out_codes, bus.out_bitmap,
              bus.out_idx, bus.out_value, bus.out_last};
   endfunction

   // Called at a negedge in IDLE; returns at the negedge where the header should be up.
   task automatic send(input vec_t v);
      bus.in_valid   = 1'b1;
      bus.in_weights = v.w;
      #1 chk("send_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_block(input vec_t v, input bit stall, input bit chain, input vec_t nxt);
      logic [63:0] s;
      for (int b = 0; b <= v.n_esc; b++) begin
         if (stall) begin
            bus.out_ready = 1'b0;
            s = snap();
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               chk("stall_hold", snap(), s);
               chk("stall_in_ready", bus.in_ready, 0);
            end
         end
         chk("beat_valid", bus.out_valid, 1);
         chk("beat_is_esc", bus.out_is_esc, b > 0);
         chk("beat_last", bus.out_last, b == v.n_esc);
         if (b == 0) begin
            chk("hdr_codes", bus.out_codes, v.codes);
            chk("hdr_bitmap", bus.out_bitmap, v.bitmap);
         end else begin
            chk("esc_idx", bus.out_idx, v.idx[b-1]);
            chk("esc_value", bus.out_value, v.val[b-1]);
         end
         bus.out_ready = 1'b1;
         if (b == v.n_esc && chain) begin
            bus.in_valid   = 1'b1;
            bus.in_weights = nxt.w;
         end
         #1 chk("beat_in_ready", bus.in_ready, b == v.n_esc);
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      vecs[0].w      = {6'h20, 6'h00, 6'h00, 6'h37, 6'h14, 6'h07, 6'h38, 6'h03};
      vecs[0].codes  = 32'h8008_7783;
      vecs[0].bitmap = 8'h98;
      vecs[0].n_esc  = 3;
      vecs[0].idx    = '0;
      vecs[0].val    = '0;
      vecs[0].idx[0] = 3'd3; vecs[0].val[0] = 6'h14;
      vecs[0].idx[1] = 3'd4; vecs[0].val[1] = 6'h37;
      vecs[0].idx[2] = 3'd7; vecs[0].val[2] = 6'h20;

      vecs[1].w      = {6'h05, 6'h3E, 6'h02, 6'h38, 6'h07, 6'h3F, 6'h01, 6'h00};
      vecs[1].codes  = 32'h5E28_7F10;
      vecs[1].bitmap = 8'h00;
      vecs[1].n_esc  = 0;
      vecs[1].idx    = '0;
      vecs[1].val    = '0;

      vecs[2].w      = {8{6'h1F}};
      vecs[2].codes  = 32'h7777_7777;
      vecs[2].bitmap = 8'hFF;
      vecs[2].n_esc  = 8;
      vecs[2].idx    = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      vecs[2].val    = {8{6'h1F}};

      // Range boundaries: 7 and -8 are inliers, 8 and -9 saturate.
      vecs[3].w      = {6'h00, 6'h00, 6'h00, 6'h00, 6'h37, 6'h08, 6'h38, 6'h07};
      vecs[3].codes  = 32'h0000_8787;
      vecs[3].bitmap = 8'h0C;
      vecs[3].n_esc  = 2;
      vecs[3].idx    = '0;
      vecs[3].val    = '0;
      vecs[3].idx[0] = 3'd2; vecs[3].val[0] = 6'h08;
      vecs[3].idx[1] = 3'd3; vecs[3].val[1] = 6'h37;

      bus.in_valid     = 1'b0;
      bus.in_weights   = '0;
      bus.out_ready    = 1'b1;
      bus16.in_valid   = 1'b0;
      bus16.in_weights = '0;
      bus16.out_ready  = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_is_esc", bus.out_is_esc, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_codes", bus.out_codes, 0);
      chk("rst_bitmap", bus.out_bitmap, 0);
      chk("rst_idx", bus.out_idx, 0);
      chk("rst_value", bus.out_value, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table run; block 1 chains into block 2 with no idle cycle.
      begin
         bit pre = 1'b0;
         for (int i = 0; i < 4; i++) begin
            bit chain = (i == 1);
            if (!pre) send(vecs[i]);
            expect_block(vecs[i], 1'b0, chain, vecs[(i + 1) % 4]);
            if (!chain) chk("idle_out_valid", bus.out_valid, 0);
            pre = chain;
         end
      end

      // Backpressure on every beat.
      send(vecs[0]);
      expect_block(vecs[0], 1'b1, 1'b0, vecs[0]);
      chk("stall_idle_valid", bus.out_valid, 0);

      // Reset after idx3 escape has been sent.
      send(vecs[0]);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_idx", bus.out_idx, 3);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_idx4", bus.out_idx, 4);
      #2 rst_n = 1'b0;
      #1 chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_bitmap", bus.out_bitmap, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_valid", bus.out_valid, 0);
      chk("postrst_in_ready", bus.in_ready, 1);
      send(vecs[1]);
      expect_block(vecs[1], 1'b0, 1'b0, vecs[1]);
      chk("postrst_idle", bus.out_valid, 0);

      // Wider configuration: N=16, W=8, C=3, weight 4 at index 9.
      bus16.in_valid   = 1'b1;
      bus16.in_weights = 128'(8'h04) << 72;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      @(negedge clk);
      chk("w16_hdr_valid", bus16.out_valid, 1);
      chk("w16_hdr_esc", bus16.out_is_esc, 0);
      chk("w16_codes", bus16.out_codes, 48'h0000_1800_0000);
      chk("w16_bitmap", bus16.out_bitmap, 16'h0200);
      chk("w16_hdr_last", bus16.out_last, 0);
      @(posedge clk);
      @(negedge clk);
      chk("w16_esc_valid", bus16.out_valid, 1);
      chk("w16_esc_flag", bus16.out_is_esc, 1);
      chk("w16_esc_idx", bus16.out_idx, 9);
      chk("w16_esc_value", bus16.out_value, 8'h04);
      chk("w16_esc_last", bus16.out_last, 1);
      @(posedge clk);
      @(negedge clk);
      chk("w16_idle", bus16.out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
